// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/issue stage and the decode stage that consumes its opcodes.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam int OPCODE_W   = 6;
  localparam int OPCODE_MSB = 31;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEF = 6'b111111;
  localparam logic [OPCODE_W-1:0] OP_RTYPE        = 6'b000000;

  // Saturating 32-bit increment for event counters
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_issue_buffer.sv
// instr_buffer: DEPTH-entry synchronous FIFO of {pc, word} with push, pop and flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_buffer #(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [AW-1:0]    i_push_pc,
  input  logic [DW-1:0]    i_push_word,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [AW-1:0]    o_head_pc,
  output logic [DW-1:0]    o_head_word,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [AW-1:0]    r_pc_mem   [DEPTH];
  logic [DW-1:0]    r_word_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_head_pc   = r_pc_mem[r_rd_ptr];
  assign o_head_word = r_word_mem[r_rd_ptr];

  // Pointers and occupancy; flush empties the FIFO regardless of push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_pc_mem[r_wr_ptr]   <= i_push_pc;
      r_word_mem[r_wr_ptr] <= i_push_word;
    end
  end

endmodule

// File: rtl/instr_fetch_issue.sv
// instr_fetch_issue: owns the PC, reads instruction memory (1-cycle latency), buffers
// returned words and issues them to decode with a valid/ready handshake.
// Optional build macro FETCH_ISSUE_STATS_EN adds issued_count and stall_cycles outputs.
module instr_fetch_issue
  import fetch_pkg::*;
#(
  parameter int                  ADDR_W      = 32,
  parameter int                  DATA_W      = 32,
  parameter int                  PC_STEP     = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC    = '0,
  parameter int                  BUF_DEPTH   = 2,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [DATA_W-1:0]   imem_rdata,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [DATA_W-1:0]   instr,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic [OPCODE_W-1:0] opcode,
  output logic                running
`ifdef FETCH_ISSUE_STATS_EN
  ,
  output logic [31:0]         issued_count,
  output logic [31:0]         stall_cycles
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_inflight;
  logic              r_req_epoch;
  logic              r_epoch;

  logic              w_req;
  logic              w_flush;
  logic              w_epoch_flip;
  logic              w_fire;
  logic              w_halt_fire;
  logic              w_push;
  logic              w_has_room;
  logic [CNT_W:0]    w_fill;
  logic [CNT_W:0]    w_limit;

  logic [ADDR_W-1:0] w_head_pc;
  logic [DATA_W-1:0] w_head_word;
  logic [CNT_W-1:0]  w_occ;
  logic              w_empty;
  logic              w_full;

  assign w_fire      = !w_empty && instr_ready;
  assign w_halt_fire = w_fire && (r_state == FETCH) &&
                       (w_head_word[DATA_W-1 -: OPCODE_W] == HALT_OPCODE);

  // A request is allowed when every outstanding word still has a slot to land in.
  // A pop this cycle frees a slot before the response arrives, which keeps
  // one instruction per cycle flowing with a two-entry buffer.
  assign w_fill     = {1'b0, w_occ} + {{CNT_W{1'b0}}, r_inflight};
  assign w_limit    = (CNT_W+1)'(BUF_DEPTH) + {{CNT_W{1'b0}}, w_fire};
  assign w_has_room = (w_fill < w_limit);

  // Responses from a request issued before a redirect/halt carry a stale epoch
  assign w_push = r_inflight && (r_req_epoch == r_epoch) && !w_full;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, fetch request and flush decisions
  always_comb begin
    w_state_nxt  = r_state;
    w_req        = 1'b0;
    w_flush      = 1'b0;
    w_epoch_flip = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_nxt = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          w_flush      = 1'b1;
          w_epoch_flip = 1'b1;
        end else if (w_halt_fire) begin
          w_state_nxt  = HALTED;
          w_flush      = 1'b1;
          w_epoch_flip = 1'b1;
        end else begin
          w_req = w_has_room;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          w_state_nxt  = FETCH;
          w_flush      = 1'b1;
          w_epoch_flip = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // PC, in-flight tracking and epoch; a redirect loads the PC in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_inflight  <= 1'b0;
      r_req_epoch <= 1'b0;
      r_epoch     <= 1'b0;
    end else begin
      if (redirect_valid) r_pc <= redirect_pc;
      else if (w_req)     r_pc <= r_pc + ADDR_W'(PC_STEP);
      r_inflight <= w_req;
      if (w_req)        r_req_epoch <= r_epoch;
      if (w_epoch_flip) r_epoch     <= ~r_epoch;
    end
  end

  // Address of the outstanding request, paired with its data on return
  always_ff @(posedge clk) begin
    if (w_req) r_req_addr <= r_pc;
  end

  instr_buffer #(
    .DEPTH (BUF_DEPTH),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_pc   (r_req_addr),
    .i_push_word (imem_rdata),
    .i_pop       (w_fire),
    .i_flush     (w_flush),
    .o_head_pc   (w_head_pc),
    .o_head_word (w_head_word),
    .o_count     (w_occ),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign instr_valid = !w_empty;
  assign instr       = w_empty ? '0 : w_head_word;
  assign instr_pc    = w_empty ? '0 : w_head_pc;
  assign opcode      = instr[DATA_W-1 -: OPCODE_W];
  assign running     = (r_state == FETCH);

`ifdef FETCH_ISSUE_STATS_EN
  // Issue and back-pressure counters; they survive redirects and only clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_count <= '0;
      stall_cycles <= '0;
    end else begin
      if (w_fire)                  issued_count <= sat_inc32(issued_count);
      if (!w_empty && !instr_ready) stall_cycles <= sat_inc32(stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Self-checking bench for instr_fetch_issue: per-cycle vector table for the
// start/stream/stall sequence plus scoreboarded redirect, halt, reset and stats sequences.
module tb_instr_fetch_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  opcode;
  logic        running;
`ifdef FETCH_ISSUE_STATS_EN
  logic [31:0] issued_count;
  logic [31:0] stall_cycles;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] halt_addr = 32'h1;
  logic        sb_en = 1'b0;
  logic [31:0] sb_q[$];
  logic [31:0] mon_e;
  logic [31:0] mon_w;

  typedef struct {
    logic        start;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[15];

  always #5 clk = ~clk;

  instr_fetch_issue dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .running        (running)
`ifdef FETCH_ISSUE_STATS_EN
    ,
    .issued_count   (issued_count),
    .stall_cycles   (stall_cycles)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == halt_addr) return {6'b111111, a[25:0]};
    return {6'b000000, a[25:0]};
  endfunction

  // instruction memory: data one cycle after the request
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: compare each completed handshake against the next expected PC
  always @(negedge clk) begin
    if (sb_en && !rst && instr_valid && instr_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_extra: issued pc 0x%0h with nothing expected", instr_pc);
      end else begin
        mon_e = sb_q.pop_front();
        mon_w = mem_word(mon_e);
        chk("sb_pc", instr_pc, mon_e);
        chk("sb_instr", instr, mon_w);
        chk("sb_opcode", {26'd0, opcode}, {26'd0, mon_w[31:26]});
      end
    end
  end

  task automatic do_reset();
    start = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    sb_en = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_valid",   32'(instr_valid), 32'd0);
    chk("rst_req",     32'(imem_req),    32'd0);
    chk("rst_running", 32'(running),     32'd0);
    chk("rst_instr",   instr,            32'd0);
    chk("rst_pc",      instr_pc,         32'd0);
    chk("rst_opcode",  32'(opcode),      32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb_q.size() != 0 && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  initial begin
    logic [31:0] w;

    //            start ready req   addr      valid pc
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h18};

    do_reset();

    // start, streaming, five-cycle stall, release
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      start = tbl[i].start;
      instr_ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
      if (tbl[i].exp_req) chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_running", i), 32'(running), 32'(i != 0));
      if (tbl[i].exp_valid) begin
        w = {6'b000000, tbl[i].exp_pc[25:0]};
        chk($sformatf("vec%0d_pc", i), instr_pc, tbl[i].exp_pc);
        chk($sformatf("vec%0d_instr", i), instr, w);
        chk($sformatf("vec%0d_opcode", i), 32'(opcode), 32'd0);
      end
    end

    // asynchronous reset while an instruction is presented
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    do_reset();
    @(negedge clk);
    chk("post_rst_running", 32'(running), 32'd0);
    chk("post_rst_req", 32'(imem_req), 32'd0);

    // redirect with one word buffered and one response arriving
    sb_en = 1'b1;
    pulse_start();
    @(negedge clk);
    chk("a_req0", 32'(imem_req), 32'd1);
    chk("a_addr0", imem_addr, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("a_addr1", imem_addr, 32'h4);
    chk("a_valid_c2", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("a_valid_c3", 32'(instr_valid), 32'd1);
    chk("a_head_pc", instr_pc, 32'h0);
    sb_q.push_back(32'h100);
    sb_q.push_back(32'h104);
    sb_q.push_back(32'h108);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("a_redir_req", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("a_flushed", 32'(instr_valid), 32'd0);
    chk("a_req_new", 32'(imem_req), 32'd1);
    chk("a_addr_new", imem_addr, 32'h100);
    wait_drain("a_drain");
    instr_ready = 1'b0;

    // redirect with a full buffer and a same-cycle handshake
    repeat (3) begin
      @(posedge clk); #1;
    end
    sb_q.push_back(32'h10C);
    sb_q.push_back(32'h200);
    sb_q.push_back(32'h204);
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    #1;
    chk("b_redir_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("b_flushed", 32'(instr_valid), 32'd0);
    wait_drain("b_drain");
    instr_ready = 1'b0;

    // halt opcode at 0x8, then redirect out of HALTED
    do_reset();
    halt_addr = 32'h8;
    sb_en = 1'b1;
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h4);
    sb_q.push_back(32'h8);
    instr_ready = 1'b1;
    pulse_start();
    wait_drain("h_drain");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("h_valid%0d", i), 32'(instr_valid), 32'd0);
      chk($sformatf("h_running%0d", i), 32'(running), 32'd0);
      chk($sformatf("h_req%0d", i), 32'(imem_req), 32'd0);
    end
    sb_q.push_back(32'h20);
    sb_q.push_back(32'h24);
    sb_q.push_back(32'h28);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    @(negedge clk);
    chk("h_redir_req", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("h_resume_running", 32'(running), 32'd1);
    chk("h_resume_req", 32'(imem_req), 32'd1);
    chk("h_resume_addr", imem_addr, 32'h20);
    wait_drain("h_resume_drain");
    instr_ready = 1'b0;
    halt_addr = 32'h1;

`ifdef FETCH_ISSUE_STATS_EN
    // ten issues with three stall cycles
    begin : stats_blk
      int k;
      do_reset();
      chk("st_issued_rst", issued_count, 32'd0);
      chk("st_stall_rst", stall_cycles, 32'd0);
      sb_en = 1'b1;
      for (int i = 0; i < 10; i++) sb_q.push_back(32'(i * 4));
      pulse_start();
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!instr_valid && k < 20);
      chk("st_first_valid", 32'(instr_valid), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      instr_ready = 1'b1;
      wait_drain("st_drain");
      instr_ready = 1'b0;
      chk("st_issued", issued_count, 32'd10);
      chk("st_stalls", stall_cycles, 32'd3);
    end
`endif

    sb_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
